// File: rtl/if_stage.sv
// if_stage: PC holder with one outstanding imem fetch and a small {inst, inst_addr} buffer toward decode
module if_stage #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_addr,
    input  logic        inst_ready
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t        state, state_n;
    logic [63:0]   pc, pc_n;
    logic [31:0]   buf_inst [DEPTH];
    logic [63:0]   buf_addr [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count, count_n;
    logic          accept, enq, deq;

    assign imem_req_valid = state == REQ;
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid & imem_req_ready;
    assign enq            = (state == WAIT) & imem_resp_valid & ~redirect_valid;
    assign inst_valid     = count != '0;
    assign deq            = inst_valid & inst_ready & ~redirect_valid;
    assign inst           = inst_valid ? buf_inst[rd_ptr] : 32'h0000_0013;
    assign inst_addr      = inst_valid ? buf_addr[rd_ptr] : 64'h0;

    // Next state, next PC and next occupancy; a redirect overrides everything and
    // routes through DROP whenever a fetch is still in flight after this edge.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        count_n = redirect_valid ? '0 : count + (AW+1)'(enq) - (AW+1)'(deq);
        if (redirect_valid) begin
            pc_n = {redirect_pc[63:2], 2'b00};
            case (state)
                IDLE:    state_n = REQ;
                REQ:     state_n = accept ? DROP : REQ;
                default: state_n = imem_resp_valid ? REQ : DROP;
            endcase
        end else begin
            case (state)
                IDLE: state_n = (count < FULL) ? REQ : IDLE;
                REQ: begin
                    state_n = accept ? WAIT : REQ;
                    pc_n    = accept ? pc + 64'd4 : pc;
                end
                WAIT:    state_n = !imem_resp_valid ? WAIT : (count_n < FULL) ? REQ : IDLE;
                default: state_n = imem_resp_valid ? REQ : DROP;
            endcase
        end
    end

    // Fetch control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_n;
            pc    <= pc_n;
        end
    end

    // Instruction buffer: the word returned in WAIT belongs to pc-4 since pc advanced on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_inst[i] <= 32'h0000_0013;
                buf_addr[i] <= 64'h0;
            end
        end else begin
            count <= count_n;
            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (enq) begin
                    buf_inst[wr_ptr] <= imem_resp_data;
                    buf_addr[wr_ptr] <= pc - 64'd4;
                    wr_ptr           <= wr_ptr + AW'(1);
                end
                if (deq) rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: stream-level scoreboard for if_stage with a latency-programmable memory model
module tb_if_stage;
    localparam logic [63:0] RP = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_addr;
    logic        inst_ready;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_acc = 0;
    int          n_del = 0;
    int          a0, d0;
    logic [63:0] pq_addr[$];
    int          pq_due[$];
    logic [63:0] exp_pc, exp_req;
    logic        chk_flush = 1'b0;
    logic [31:0] key = 32'h0;

    if_stage dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst(inst), .inst_addr(inst_addr), .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ key;
    endfunction

    // One clock: observe at negedge, account for the upcoming edge, then drive the memory side
    task automatic cycle();
        @(negedge clk);
        if (chk_flush) check("flush", 96'(inst_valid), 96'(0));
        chk_flush = 1'b0;
        if (!inst_valid) check("idle_out", {inst, inst_addr}, {32'h13, 64'h0});
        if (imem_req_valid) check("req_align", 96'(imem_req_addr[1:0]), 96'(0));
        if (imem_resp_valid) begin
            void'(pq_addr.pop_front());
            void'(pq_due.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", 96'(imem_req_addr), 96'(exp_req));
            check("credit", 96'(pq_addr.size()), 96'(0));
            pq_addr.push_back(imem_req_addr);
            pq_due.push_back(cyc + lat);
            n_acc++;
        end
        if (redirect_valid) begin
            exp_pc    = {redirect_pc[63:2], 2'b00};
            exp_req   = exp_pc;
            chk_flush = 1'b1;
        end else begin
            if (imem_req_valid && imem_req_ready) exp_req = exp_req + 64'd4;
            if (inst_valid && inst_ready) begin
                check("deliver", {inst, inst_addr}, {mem_word(exp_pc), exp_pc});
                exp_pc = exp_pc + 64'd4;
                n_del++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid  = 1'b0;
        imem_resp_valid = (pq_addr.size() > 0) && (pq_due[0] <= cyc);
        imem_resp_data  = imem_resp_valid ? mem_word(pq_addr[0]) : $urandom;
    endtask

    // Asynchronous reset entry: outputs must fall back before any clock edge
    task automatic do_reset();
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        pq_addr.delete();
        pq_due.delete();
        #1;
        check("rst_req", {31'h0, imem_req_valid, imem_req_addr}, {31'h0, 1'b0, RP});
        check("rst_inst", {inst_valid, inst, inst_addr[62:0]}, {1'b0, 32'h13, 63'h0});
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        exp_pc    = RP;
        exp_req   = RP;
        chk_flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0; inst_ready = 1'b1;
        #2;

        // basic flow: first request at RESET_PC, 2-cycle accept-to-valid latency
        do_reset();
        inst_ready = 1'b1; lat = 1;
        cycle();
        check("first_req", {31'h0, imem_req_valid, imem_req_addr}, {31'h0, 1'b1, RP});
        cycle();
        cycle();
        check("first_inst", {inst_valid, inst, inst_addr[62:0]}, {1'b1, RP[31:0], RP[62:0]});
        d0 = n_del;
        repeat (12) cycle();
        check("stream_prog", 96'(n_del - d0 >= 4), 96'(1));

        // back-pressure: exactly DEPTH entries buffered, then resume without loss
        do_reset();
        inst_ready = 1'b0; a0 = n_acc;
        repeat (20) cycle();
        check("bp_acc", 96'(n_acc - a0), 96'(2));
        check("bp_head", {imem_req_valid, inst_valid, inst_addr[63:2], 32'h0}, {1'b0, 1'b1, RP[63:2], 32'h0});
        inst_ready = 1'b1; d0 = n_del;
        repeat (15) cycle();
        check("bp_resume", 96'(n_del - d0 >= 4), 96'(1));

        // redirect while WAIT: in-flight response dropped, refetch at aligned target
        do_reset();
        inst_ready = 1'b1; lat = 4; a0 = n_acc;
        for (int k = 0; k < 20 && n_acc == a0; k++) cycle();
        check("t3_acc", 96'(n_acc - a0), 96'(1));
        redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_0103;
        cycle();
        check("t3_drop", 96'(imem_req_valid), 96'(0));
        lat = 1; d0 = n_del;
        for (int k = 0; k < 20 && n_del == d0; k++) cycle();
        check("t3_deliv", 96'(n_del > d0), 96'(1));

        // redirect coinciding with a response: no DROP cycle, FIFO with entries flushed
        do_reset();
        inst_ready = 1'b0; lat = 1; a0 = n_acc;
        for (int k = 0; k < 20 && !(imem_resp_valid && n_acc - a0 == 2); k++) cycle();
        check("t4_resp", 96'(imem_resp_valid), 96'(1));
        redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_0400;
        cycle();
        check("t4_req", {31'h0, imem_req_valid, imem_req_addr}, {31'h0, 1'b1, 64'h0000_0000_8000_0400});
        inst_ready = 1'b1; d0 = n_del;
        repeat (10) cycle();
        check("t4_deliv", 96'(n_del > d0), 96'(1));

        // request stall: held valid and stable address, redirect retargets the pending request
        do_reset();
        inst_ready = 1'b1; imem_req_ready = 1'b0;
        cycle();
        for (int k = 0; k < 5; k++) begin
            check("stall_hold", {31'h0, imem_req_valid, imem_req_addr}, {31'h0, 1'b1, RP});
            cycle();
        end
        redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_0202;
        cycle();
        check("stall_redir", {31'h0, imem_req_valid, imem_req_addr}, {31'h0, 1'b1, 64'h0000_0000_8000_0200});
        imem_req_ready = 1'b1; d0 = n_del;
        repeat (10) cycle();
        check("stall_deliv", 96'(n_del > d0), 96'(1));

        // asynchronous reset mid-WAIT with one entry buffered
        do_reset();
        inst_ready = 1'b0; lat = 5; a0 = n_acc;
        for (int k = 0; k < 40 && n_acc - a0 < 2; k++) cycle();
        check("t6_acc", 96'(n_acc - a0), 96'(2));
        check("t6_pre", {94'h0, inst_valid, imem_req_valid}, {94'h0, 1'b1, 1'b0});
        do_reset();
        inst_ready = 1'b1; lat = 1; d0 = n_del;
        for (int k = 0; k < 20 && n_del == d0; k++) cycle();
        check("t6_refetch", 96'(n_del > d0), 96'(1));

        // randomized traffic, redirects including targets near the top of the address space
        key = 32'hC0DE_F00D;
        do_reset();
        for (int k = 0; k < 800; k++) begin
            inst_ready     = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            lat            = $urandom_range(1, 4);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = $urandom_range(0, 1) != 0 ? {32'h0, 32'($urandom)}
                                                       : (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)));
            cycle();
        end
        inst_ready = 1'b1; imem_req_ready = 1'b1; lat = 1; d0 = n_del;
        repeat (20) cycle();
        check("drain", 96'(n_del > d0), 96'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
